// File: rtl/reg_bank_pkg.sv
// Shared types and constants for the register-bank sequencer: FSM states,
// a width helper and the bit layout of the green status LEDs.
package reg_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_COPY  = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int width_for(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int LEDG_W       = 8;
    localparam int LEDG_BUSY    = 7;
    localparam int LEDG_FULL    = 6;
    localparam int LEDG_PTR_LSB = 0;
    localparam int LEDG_PTR_W   = 6;

endpackage

// File: rtl/key_edge.sv
// Two-flop synchroniser for a raw key level followed by a rising-edge
// detector; a held key yields a single one-cycle push.
module key_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic push
);

    logic stage1;
    logic stage2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage1 <= 1'b0;
            stage2 <= 1'b0;
        end else begin
            stage1 <= key;
            stage2 <= stage1;
        end
    end

    assign push = stage1 & ~stage2;

endmodule

// File: rtl/reg_bank_sequencer.sv
// Key-driven load/copy/clear sequencer for a small bank of switch snapshots.
// Optional build macro SCAN_AUTO_EN: timed auto-scan of the displayed slot.
module reg_bank_sequencer
    import reg_bank_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int SCAN_DIV = 50_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_load,
    input  logic             key_copy,
    input  logic             key_clr,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] leds,
    output logic [LEDG_W-1:0] ledg
);

    localparam int PTR_W = width_for(DEPTH);
    localparam int CNT_W = width_for(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

    if (SCAN_DIV < 2 || DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("reg_bank_sequencer: unsupported DEPTH/SCAN_DIV");
    end

    logic push_load;
    logic push_copy;
    logic push_clr;

    key_edge u_edge_load (.clk(clk), .rst_n(rst_n), .key(key_load), .push(push_load));
    key_edge u_edge_copy (.clk(clk), .rst_n(rst_n), .key(key_copy), .push(push_copy));
    key_edge u_edge_clr  (.clk(clk), .rst_n(rst_n), .key(key_clr),  .push(push_clr));

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] bank [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] disp_ptr;
    logic [PTR_W-1:0] clr_idx;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             full;
    logic             clr_last;
    logic             wr_en;
    logic             advance;
    logic [WIDTH-1:0] wr_data;

    assign busy     = (state != ST_IDLE);
    assign full     = (count == CNT_FULL);
    assign clr_last = (state == ST_CLEAR) && (clr_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Only IDLE looks at pushes, so anything arriving while busy is lost.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (push_clr) begin
                    next_state = ST_CLEAR;
                end else if (push_load) begin
                    next_state = ST_LOAD;
                end else if (push_copy) begin
                    next_state = ST_COPY;
                end
            end
            ST_LOAD:  next_state = ST_IDLE;
            ST_COPY:  next_state = ST_IDLE;
            ST_CLEAR: begin
                if (clr_last) begin
                    next_state = ST_IDLE;
                end
            end
            default:  next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_en   = 1'b0;
        advance = 1'b0;
        wr_data = sw;
        case (state)
            ST_LOAD: begin
                wr_en   = 1'b1;
                advance = 1'b1;
            end
            ST_COPY: begin
                if (count != '0) begin
                    wr_en   = 1'b1;
                    advance = 1'b1;
                    wr_data = bank[disp_ptr];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
        end else if (state == ST_CLEAR) begin
            bank[clr_idx] <= '0;
        end else if (wr_en) begin
            bank[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            count   <= '0;
            clr_idx <= '0;
        end else begin
            clr_idx <= (state == ST_CLEAR) ? clr_idx + PTR_W'(1) : '0;
            if (clr_last) begin
                wr_ptr <= '0;
                count  <= '0;
            end else if (advance) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (!full) begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

`ifdef SCAN_AUTO_EN
    localparam int TMR_W = width_for(SCAN_DIV);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SCAN_DIV - 1);

    logic [TMR_W-1:0] scan_timer;
    logic [CNT_W-1:0] disp_inc;

    assign disp_inc = CNT_W'(disp_ptr) + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_timer <= '0;
            disp_ptr   <= '0;
        end else if (clr_last) begin
            scan_timer <= '0;
            disp_ptr   <= '0;
        end else if (busy || count == '0) begin
            scan_timer <= '0;
        end else if (scan_timer == TMR_LAST) begin
            scan_timer <= '0;
            disp_ptr   <= (disp_inc >= count) ? '0 : disp_ptr + PTR_W'(1);
        end else begin
            scan_timer <= scan_timer + TMR_W'(1);
        end
    end
`else
    // Follow the most recent write.
    always_comb begin
        disp_ptr = (count != '0) ? wr_ptr - PTR_W'(1) : '0;
    end
`endif

    assign leds = bank[disp_ptr];

    always_comb begin
        ledg = '0;
        ledg[LEDG_BUSY] = busy;
        ledg[LEDG_FULL] = full;
        ledg[LEDG_PTR_LSB +: PTR_W] = disp_ptr;
    end

endmodule

// File: tb/tb_reg_bank_sequencer.sv
// Directed bench for reg_bank_sequencer: an operation-level model of the bank
// is checked against leds/ledg every cycle, plus hand-computed spot checks.
module tb_reg_bank_sequencer;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 4;
    localparam int SCAN_DIV = 4;

    logic             clk;
    logic             rst_n;
    logic             key_load;
    logic             key_copy;
    logic             key_clr;
    logic [WIDTH-1:0] sw;
    logic [WIDTH-1:0] leds;
    logic [7:0]       ledg;

    reg_bank_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_copy(key_copy),
        .key_clr(key_clr), .sw(sw), .leds(leds), .ledg(ledg)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    // Operations: 1 load, 2 copy, 3 clear. m_left = edges of work remaining.
    logic [WIDTH-1:0] m_bank [DEPTH];
    int m_wr, m_cnt, m_disp, m_timer, m_op, m_left;
    bit p_load, p_copy, p_clr, kp_load, kp_copy, kp_clr;

    function automatic int model_disp();
`ifdef SCAN_AUTO_EN
        return m_disp;
`else
        return (m_cnt > 0) ? (m_wr + DEPTH - 1) % DEPTH : 0;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) m_bank[i] = '0;
            m_wr = 0; m_cnt = 0; m_disp = 0; m_timer = 0; m_op = 0; m_left = 0;
            p_load = 0; p_copy = 0; p_clr = 0; kp_load = 0; kp_copy = 0; kp_clr = 0;
        end else begin
            int d;
            bit idle;
            d    = model_disp();
            idle = (m_left == 0);
`ifdef SCAN_AUTO_EN
            if (idle && m_cnt > 0) begin
                if (m_timer == SCAN_DIV - 1) begin
                    m_timer = 0;
                    m_disp  = (m_disp + 1) % m_cnt;
                end else begin
                    m_timer++;
                end
            end else begin
                m_timer = 0;
            end
`endif
            if (idle) begin
                if (p_clr) begin
                    m_op = 3; m_left = DEPTH;
                end else if (p_load) begin
                    m_op = 1; m_left = 1;
                end else if (p_copy) begin
                    m_op = 2; m_left = 1;
                end
            end else begin
                if (m_op == 1 || (m_op == 2 && m_cnt > 0)) begin
                    m_bank[m_wr] = (m_op == 1) ? sw : m_bank[d];
                    m_wr  = (m_wr + 1) % DEPTH;
                    m_cnt = (m_cnt < DEPTH) ? m_cnt + 1 : DEPTH;
                end else if (m_op == 3) begin
                    m_bank[DEPTH - m_left] = '0;
                    if (m_left == 1) begin
                        m_wr = 0; m_cnt = 0; m_disp = 0; m_timer = 0;
                    end
                end
                m_left--;
            end
            p_load = key_load && !kp_load; kp_load = key_load;
            p_copy = key_copy && !kp_copy; kp_copy = key_copy;
            p_clr  = key_clr  && !kp_clr;  kp_clr  = key_clr;
        end
    end

    // ---------------- scoreboard / compare ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int busy_total = 0;
    int lit_seq = 0;
    int lit_done = 0;
    int lit_kind;
    int lit_exp;
    int lit_mask;
    int busy_base;
    string lit_name;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int d;
        if (ledg[7]) busy_total++;
        if (rst_n) begin
            d = model_disp();
            check("leds", int'(leds), int'(m_bank[d]));
            check("ledg", int'(ledg),
                  ((m_left != 0) ? 128 : 0) + ((m_cnt == DEPTH) ? 64 : 0) + d);
        end
        if (lit_seq != lit_done) begin
            lit_done = lit_seq;
            case (lit_kind)
                0:       check(lit_name, int'(leds), lit_exp);
                1:       check(lit_name, int'(ledg) & lit_mask, lit_exp & lit_mask);
                default: check(lit_name, busy_total - busy_base, lit_exp);
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic lit(input int kind, input string name, input int exp, input int mask);
        lit_kind = kind; lit_name = name; lit_exp = exp; lit_mask = mask;
        lit_seq++;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; key_load = 0; key_copy = 0; key_clr = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic press(input int which, input int hold);
        @(negedge clk);
        case (which)
            0:       key_load = 1'b1;
            1:       key_copy = 1'b1;
            default: key_clr  = 1'b1;
        endcase
        repeat (hold) @(negedge clk);
        key_load = 0; key_copy = 0; key_clr = 0;
        repeat (4) @(negedge clk);
    endtask

    task automatic load(input logic [WIDTH-1:0] v, input int hold);
        sw = v;
        press(0, hold);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 1'b0; key_load = 0; key_copy = 0; key_clr = 0; sw = '0;
        do_reset();
        lit(0, "reset_leds", 8'h00, 0);
        lit(1, "reset_ledg", 8'h00, 8'hFF);
        repeat (5) @(negedge clk);
        lit(2, "idle_no_push", 0, 0);

        // copy with an empty bank: one busy cycle, nothing written
        busy_base = busy_total;
        press(1, 2);
        lit(2, "copy_empty_busy", 1, 0);
        lit(0, "copy_empty_leds", 8'h00, 0);
        lit(1, "copy_empty_ledg", 8'h00, 8'hFF);

        // single load held for 10 cycles
        busy_base = busy_total;
        load(8'hA5, 10);
        lit(2, "load_busy", 1, 0);
        lit(0, "load_leds", 8'hA5, 0);
        lit(1, "load_ledg", 8'h00, 8'hFF);

        // load then copy from a fresh bank
        do_reset();
        load(8'h3C, 2);
        press(1, 2);
        lit(0, "copy_leds", 8'h3C, 0);
        lit(1, "copy_status", 8'h00, 8'hC0);
`ifndef SCAN_AUTO_EN
        lit(1, "copy_ledg", 8'h01, 8'hFF);
`endif

        // wrap and full
        do_reset();
        for (int i = 1; i <= 4; i++) load(WIDTH'(i), 2);
        lit(1, "full_after_4", 8'h40, 8'hC0);
        load(8'h05, 2);
        lit(1, "full_after_5", 8'h40, 8'hC0);
`ifndef SCAN_AUTO_EN
        lit(0, "wrap_leds", 8'h05, 0);
        lit(1, "wrap_ledg", 8'h40, 8'hFF);
`endif

        // clear beats a simultaneous load; a load pushed mid-clear is dropped
        do_reset();
        load(8'h10, 2);
        load(8'h20, 2);
        load(8'h30, 2);
        busy_base = busy_total;
        @(negedge clk);
        sw = 8'hEE; key_clr = 1'b1; key_load = 1'b1;
        repeat (3) @(negedge clk);
        key_load = 1'b0;
        @(negedge clk);
        key_load = 1'b1;
        repeat (2) @(negedge clk);
        key_load = 1'b0; key_clr = 1'b0;
        repeat (8) @(negedge clk);
        lit(2, "clear_busy_cycles", DEPTH, 0);
        lit(0, "clear_leds", 8'h00, 0);
        lit(1, "clear_ledg", 8'h00, 8'hFF);

        // reset asserted in the middle of a clear
        load(8'h77, 2);
        @(negedge clk);
        key_clr = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0; key_clr = 1'b0;
        lit(0, "midclr_reset_leds", 8'h00, 0);
        lit(1, "midclr_reset_ledg", 8'h00, 8'hFF);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        lit(1, "after_reset_ledg", 8'h00, 8'hFF);

`ifdef SCAN_AUTO_EN
        do_reset();
        load(8'h11, 2);
        load(8'h22, 2);
        repeat (20) @(negedge clk);
`endif

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_bank_sequencer.md
Name: reg_bank_sequencer

Overview:
Push-button-driven controller for a small register bank of switch snapshots shown on the board LEDs. Three keys request load, copy and clear operations on the shared bank. A priority arbiter and FSM sequence one operation at a time. A scan pointer selects which slot is shown on leds while status is shown on ledg.

Parameters:
WIDTH, 8, bits per bank slot; equals sw and leds width.
DEPTH, 4, number of slots; power of two, 2..64.
SCAN_DIV, 50_000_000, clock cycles per display slot when auto-scan is compiled in; minimum 2.

Ports:
clk  input  1  system clock; all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
key_load  input  1  raw key level; a rising edge requests a LOAD.
key_copy  input  1  raw key level; a rising edge requests a COPY.
key_clr  input  1  raw key level; a rising edge requests a CLEAR.
sw  input  WIDTH  switch value captured by LOAD.
leds  output  WIDTH  contents of bank[disp_ptr].
ledg  output  8  status: [7]=busy, [6]=full, [5:0]=disp_ptr zero-extended.

Behaviour:
- Reset (rst_n low, asynchronous): all slots 0, wr_ptr=0, disp_ptr=0, count=0, state IDLE, scan timer 0. leds=0, ledg=0. Reset asserted mid-CLEAR aborts it immediately.
- Key inputs: each key passes through a 2-flop synchroniser. push = stage1 & ~stage2, a one-cycle pulse per rising edge. A held key gives exactly one push.
- FSM states: IDLE, LOAD, COPY, CLEAR. busy=1 in any state except IDLE.
- IDLE: sample the push pulses. Priority is clr > load > copy. Lower-priority pushes in the same cycle are dropped, not queued.
- LOAD, one cycle: bank[wr_ptr] <= sw (sw value sampled in the LOAD cycle). wr_ptr wraps modulo DEPTH. count saturates at DEPTH. Return to IDLE.
- LOAD when full: overwrites the oldest slot (the wrapped wr_ptr). count stays DEPTH.
- COPY, one cycle, count>0: bank[wr_ptr] <= bank[disp_ptr], then wr_ptr and count update as for LOAD. Return to IDLE.
- COPY with count==0: no write, no pointer change. Return to IDLE.
- CLEAR, DEPTH cycles: zero one slot per cycle using an internal index from 0 to DEPTH-1. In the final cycle, set wr_ptr=0, disp_ptr=0, count=0 and scan timer 0, then return to IDLE.
- Pushes arriving while busy are ignored, including a new clr during CLEAR.
- Latency: a key high sampled at edge k gives push during cycle k..k+1. The FSM enters LOAD at edge k+1, and the bank write completes at edge k+2. leds reflect the write after edge k+2 if disp_ptr addresses that slot.
- full = (count==DEPTH).
- leds and ledg are combinational from registers; there are no output flops.

Optional Feature:
SCAN_AUTO_EN
- Defined: while not busy and count>0, a timer counts to SCAN_DIV-1. At that point disp_ptr advances modulo count (wraps to 0 after count-1) and the timer restarts. The timer is held at 0 while busy or when count==0.
- Not defined: disp_ptr = (wr_ptr-1) mod DEPTH when count>0, otherwise 0, so the display always shows the most recent write. No timer logic is present.

Decomposition:
- Package reg_bank_pkg holds:
  - the state enum (IDLE, LOAD, COPY, CLEAR);
  - localparam PTR_W = $clog2(DEPTH) and CNT_W = $clog2(DEPTH+1), derived in the module from the parameter with a package helper function;
  - the ledg bit-position constants.
- One sub-module, key_edge: the 2-flop synchroniser plus rising-edge pulse, with its own async active-low reset. It is instantiated three times.

Test Plan:
- Reset then idle: rst_n low mid-operation, then released -> leds=0x00, ledg=0x00, no pushes generated while keys stay low.
- Single load: sw=0xA5, key_load pulsed and held 10 cycles -> exactly one write; leds=0xA5 two cycles after the push; ledg[7] high for one cycle; count=1.
- Wrap and full (DEPTH=4): five loads with sw=0x01..0x05 -> ledg[6]=1 after the 4th load; slot0=0x05; without SCAN_AUTO_EN leds=0x05.
- Copy: load 0x3C, then copy -> slot1=0x3C, count=2. Copy immediately after reset -> no write, ledg[7] high for one cycle only.
- Clear and priority: load three values, then key_clr and key_load rising in the same cycle -> CLEAR wins, busy high for exactly DEPTH cycles, all slots 0, count 0. A load pushed mid-CLEAR is ignored.
- Auto-scan (SCAN_AUTO_EN, SCAN_DIV=4): load 0x11, 0x22 -> leds alternates 0x11/0x22 every 4 cycles; ledg[5:0] toggles 0/1.
